// File: rtl/sort_pkg.sv
// Shared sorter package: word width, slot indices and the loader state enum.
// Used by the frame loader, the 4:1 selector and the sorter core.
package sort_pkg;
    localparam int DATA_W    = 16;
    localparam int NUM_SLOTS = 4;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;
endpackage

// File: rtl/sort_frame_loader_if.sv
// Word stream in, four-slot frame out. in_last exists only with SORT_FRAME_FLUSH_EN.
// master = word source / frame consumer, slave = loader.
interface sort_frame_loader_if #(parameter int DATA_W = sort_pkg::DATA_W);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
`ifdef SORT_FRAME_FLUSH_EN
    logic              in_last;
`endif
    logic              frame_valid;
    logic              frame_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic [1:0]        wr_ptr;

    modport master (
        output in_valid, in_data, frame_ready,
`ifdef SORT_FRAME_FLUSH_EN
        output in_last,
`endif
        input  in_ready, frame_valid, a, b, c, d, wr_ptr
    );

    modport slave (
        input  in_valid, in_data, frame_ready,
`ifdef SORT_FRAME_FLUSH_EN
        input  in_last,
`endif
        output in_ready, frame_valid, a, b, c, d, wr_ptr
    );
endinterface

// File: rtl/sort_frame_loader_slot_reg.sv
// One frame slot: DATA_W register with write-enable and synchronous clear.
module slot_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || i_clr) r_q <= '0;
        else if (i_we)    r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/sort_frame_loader.sv
// Steers a word stream into slots a..d and hands the full frame to the sorter core.
// Optional short-frame flush (zero-fill of upper slots) via SORT_FRAME_FLUSH_EN.
module sort_frame_loader #(
    parameter int DATA_W = sort_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    sort_frame_loader_if.slave bus
);
    import sort_pkg::*;

    state_t                             r_state, w_state_nxt;
    logic [1:0]                         r_wr_ptr, w_ptr_nxt;
    logic                               w_acc;
    logic                               w_last;
    logic [NUM_SLOTS-1:0]               w_we;
    logic [NUM_SLOTS-1:0]               w_clr;
    logic [NUM_SLOTS-1:0][DATA_W-1:0]   w_q;

    assign w_acc = bus.in_valid && (r_state == FILL);

`ifdef SORT_FRAME_FLUSH_EN
    // in_last on slot d is just a normal fourth word
    assign w_last = w_acc && bus.in_last && (r_wr_ptr != SLOT_D);
`else
    assign w_last = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_wr_ptr;
        w_we        = '0;
        w_clr       = '0;
        case (r_state)
            FILL: begin
                if (w_acc) begin
                    w_we[r_wr_ptr] = 1'b1;
                    for (int i = 0; i < NUM_SLOTS; i++)
                        if (w_last && (2'(i) > r_wr_ptr)) w_clr[i] = 1'b1;
                    if (r_wr_ptr == SLOT_D || w_last) begin
                        w_state_nxt = FULL;
                        w_ptr_nxt   = SLOT_A;
                    end else begin
                        w_ptr_nxt   = r_wr_ptr + 2'd1;
                    end
                end
            end
            FULL: begin
                if (bus.frame_ready) w_state_nxt = FILL;
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= FILL;
            r_wr_ptr <= SLOT_A;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_ptr_nxt;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        slot_reg #(.DATA_W(DATA_W)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .i_we  (w_we[g]),
            .i_clr (w_clr[g]),
            .i_d   (bus.in_data),
            .o_q   (w_q[g])
        );
    end

    // handshake outputs decode state only, so frame_ready never reaches in_ready
    assign bus.in_ready    = (r_state == FILL);
    assign bus.frame_valid = (r_state == FULL);
    assign bus.a           = w_q[SLOT_A];
    assign bus.b           = w_q[SLOT_B];
    assign bus.c           = w_q[SLOT_C];
    assign bus.d           = w_q[SLOT_D];
    assign bus.wr_ptr      = r_wr_ptr;
endmodule
